// File: rtl/wb_arbiter.sv
// Write-back arbiter: one-entry slot per producer (ALU/MUL/DIV), round-robin onto one RF port.
// Optional stall counter output enabled by defining WBARB_STALL_CNT_EN.
module wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic              mul_valid,
  input  logic              div_valid,
  output logic              alu_ready,
  output logic              mul_ready,
  output logic              div_ready,
  input  logic [ADDR_W-1:0] alu_waddr,
  input  logic [ADDR_W-1:0] mul_waddr,
  input  logic [ADDR_W-1:0] div_waddr,
  input  logic [DATA_W-1:0] alu_wdata,
  input  logic [DATA_W-1:0] mul_wdata,
  input  logic [DATA_W-1:0] div_wdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       pending,
  output logic              waw_err
`ifdef WBARB_STALL_CNT_EN
  , output logic [31:0]     stall_cnt
`endif
);

  localparam int unsigned NumSrc = 3;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    logic [2:0] t;
    t = (v >= 3'd3) ? v - 3'd3 : v;
    return t[1:0];
  endfunction

  logic [NumSrc-1:0] in_valid;
  logic [ADDR_W-1:0] in_addr [NumSrc];
  logic [DATA_W-1:0] in_data [NumSrc];

  assign in_valid   = {div_valid, mul_valid, alu_valid};
  assign in_addr[0] = alu_waddr;
  assign in_addr[1] = mul_waddr;
  assign in_addr[2] = div_waddr;
  assign in_data[0] = alu_wdata;
  assign in_data[1] = mul_wdata;
  assign in_data[2] = div_wdata;

  logic [NumSrc-1:0] h_valid_q, h_valid_d;
  logic [ADDR_W-1:0] h_addr_q [NumSrc];
  logic [ADDR_W-1:0] h_addr_d [NumSrc];
  logic [DATA_W-1:0] h_data_q [NumSrc];
  logic [DATA_W-1:0] h_data_d [NumSrc];
  logic [1:0]        ptr_q, ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              waw_err_q, waw_err_d;

  logic [NumSrc-1:0] grant, ready, xfer, accept;
  logic [1:0]        gnt_idx, cand;
  logic [31:0]       pending_vec;
  logic              waw_hit;

  // Walk candidates from last to first so the one nearest the pointer wins.
  always_comb begin
    grant   = '0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int o = NumSrc - 1; o >= 0; o--) begin
      cand = wrap3({1'b0, ptr_q} + 3'(o));
      if (h_valid_q[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        gnt_idx     = cand;
      end
    end
  end

  assign ready = ~h_valid_q | grant;
  assign xfer  = in_valid & ready;

  always_comb begin
    for (int i = 0; i < NumSrc; i++) begin
      accept[i] = xfer[i] && (in_addr[i] != '0);
    end
  end

  always_comb begin
    pending_vec = '0;
    for (int i = 0; i < NumSrc; i++) begin
      if (h_valid_q[i]) pending_vec = pending_vec | (32'd1 << h_addr_q[i]);
    end
    if (rf_we_q) pending_vec = pending_vec | (32'd1 << rf_waddr_q);
    pending_vec[0] = 1'b0;
  end

  always_comb begin
    waw_hit = 1'b0;
    for (int i = 0; i < NumSrc; i++) begin
      if (accept[i] && |(pending_vec & (32'd1 << in_addr[i]))) waw_hit = 1'b1;
      for (int j = i + 1; j < NumSrc; j++) begin
        if (accept[i] && accept[j] && (in_addr[i] == in_addr[j])) waw_hit = 1'b1;
      end
    end
    waw_err_d = waw_err_q | waw_hit;
  end

  // A draining slot may refill in the same cycle; zero-register results are dropped.
  always_comb begin
    for (int i = 0; i < NumSrc; i++) begin
      h_valid_d[i] = h_valid_q[i] & ~grant[i];
      h_addr_d[i]  = h_addr_q[i];
      h_data_d[i]  = h_data_q[i];
      if (xfer[i]) begin
        h_valid_d[i] = accept[i];
        h_addr_d[i]  = in_addr[i];
        h_data_d[i]  = in_data[i];
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    rf_we_d    = |grant;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (|grant) begin
      ptr_d      = wrap3({1'b0, gnt_idx} + 3'd1);
      rf_waddr_d = h_addr_q[gnt_idx];
      rf_wdata_d = h_data_q[gnt_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_valid_q  <= '0;
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      waw_err_q  <= 1'b0;
      for (int i = 0; i < NumSrc; i++) begin
        h_addr_q[i] <= '0;
        h_data_q[i] <= '0;
      end
    end else begin
      h_valid_q  <= h_valid_d;
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      waw_err_q  <= waw_err_d;
      for (int i = 0; i < NumSrc; i++) begin
        h_addr_q[i] <= h_addr_d[i];
        h_data_q[i] <= h_data_d[i];
      end
    end
  end

`ifdef WBARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (|(in_valid & ~ready)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign alu_ready = ready[0];
  assign mul_ready = ready[1];
  assign div_ready = ready[2];
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign pending   = pending_vec;
  assign waw_err   = waw_err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter: per-cycle stimulus/expectation table plus
// hand-written async-reset and (when enabled) stall-counter sequences.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mul_valid, div_valid;
  logic        alu_ready, mul_ready, div_ready;
  logic [4:0]  alu_waddr, mul_waddr, div_waddr;
  logic [31:0] alu_wdata, mul_wdata, div_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;
  logic        waw_err;
`ifdef WBARB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
`ifdef WBARB_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .mul_valid (mul_valid),
    .div_valid (div_valid),
    .alu_ready (alu_ready),
    .mul_ready (mul_ready),
    .div_ready (div_ready),
    .alu_waddr (alu_waddr),
    .mul_waddr (mul_waddr),
    .div_waddr (div_waddr),
    .alu_wdata (alu_wdata),
    .mul_wdata (mul_wdata),
    .div_wdata (div_wdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pending   (pending),
    .waw_err   (waw_err)
  );

  // v is {div, mul, alu}; rdy likewise.
  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pend;
    logic        waw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [2:0] v,
                              input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] a2, input logic [31:0] d2,
                              input logic [2:0] rdy, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic [31:0] pend, input logic waw);
    vec_t t;
    t.rst = r;  t.v = v;
    t.a0 = a0;  t.d0 = d0;  t.a1 = a1;  t.d1 = d1;  t.a2 = a2;  t.d2 = d2;
    t.rdy = rdy; t.we = we; t.wa = wa; t.wd = wd; t.pend = pend; t.waw = waw;
    return t;
  endfunction

  function automatic vec_t idle(input logic r, input logic [2:0] rdy, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd,
                                input logic [31:0] pend, input logic waw);
    return mk(r, 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, rdy, we, wa, wd, pend, waw);
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst       = t.rst;
    alu_valid = t.v[0]; alu_waddr = t.a0; alu_wdata = t.d0;
    mul_valid = t.v[1]; mul_waddr = t.a1; mul_wdata = t.d1;
    div_valid = t.v[2]; div_waddr = t.a2; div_wdata = t.d2;
  endtask

  task automatic set_idle();
    alu_valid = 1'b0; mul_valid = 1'b0; div_valid = 1'b0;
    alu_waddr = '0; mul_waddr = '0; div_waddr = '0;
    alu_wdata = '0; mul_wdata = '0; div_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();

    // Single ALU write to r5.
    vecs.push_back(mk(0, 3'b001, 5'd5, 32'h1234, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0, 0));
    vecs.push_back(idle(0, 3'b111, 0, 5'd0, 32'h0, 32'h20, 0));
    vecs.push_back(idle(0, 3'b111, 1, 5'd5, 32'h1234, 32'h20, 0));
    vecs.push_back(idle(0, 3'b111, 0, 5'd5, 32'h1234, 32'h0, 0));
    // Reset, then all three producers at once; drains r1, r2, r3.
    vecs.push_back(idle(1, 3'b111, 0, 5'd0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 3'b111, 5'd1, 32'hA, 5'd2, 32'hB, 5'd3, 32'hC,
                      3'b111, 0, 0, 0, 0, 0));
    vecs.push_back(idle(0, 3'b001, 0, 5'd0, 32'h0, 32'h0E, 0));
    vecs.push_back(idle(0, 3'b011, 1, 5'd1, 32'hA, 32'h0E, 0));
    vecs.push_back(idle(0, 3'b111, 1, 5'd2, 32'hB, 32'h0C, 0));
    vecs.push_back(idle(0, 3'b111, 1, 5'd3, 32'hC, 32'h08, 0));
    vecs.push_back(idle(0, 3'b111, 0, 5'd3, 32'hC, 32'h0, 0));
    // Write to r0 is accepted and dropped.
    vecs.push_back(mk(0, 3'b010, 0, 0, 5'd0, 32'hFFFF_FFFF, 0, 0,
                      3'b111, 0, 5'd3, 32'hC, 0, 0));
    vecs.push_back(idle(0, 3'b111, 0, 5'd3, 32'hC, 32'h0, 0));
    vecs.push_back(idle(0, 3'b111, 0, 5'd3, 32'hC, 32'h0, 0));
    // WAW on r7, then reset with two slots loaded.
    vecs.push_back(mk(0, 3'b001, 5'd7, 32'h77, 0, 0, 0, 0, 3'b111, 0, 5'd3, 32'hC, 0, 0));
    vecs.push_back(mk(0, 3'b010, 0, 0, 5'd7, 32'h88, 0, 0,
                      3'b111, 0, 5'd3, 32'hC, 32'h80, 0));
    vecs.push_back(idle(0, 3'b111, 1, 5'd7, 32'h77, 32'h80, 1));
    vecs.push_back(mk(0, 3'b101, 5'd9, 32'h99, 0, 0, 5'd10, 32'hAA,
                      3'b111, 1, 5'd7, 32'h88, 32'h80, 1));
    vecs.push_back(idle(1, 3'b111, 0, 5'd0, 32'h0, 32'h0, 0));
    vecs.push_back(idle(0, 3'b111, 0, 5'd0, 32'h0, 32'h0, 0));
    vecs.push_back(idle(0, 3'b111, 0, 5'd0, 32'h0, 32'h0, 0));
    // DIV streams to r4 while ALU pulses r6; round-robin alternates.
    vecs.push_back(mk(0, 3'b100, 0, 0, 0, 0, 5'd4, 32'd1, 3'b111, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b101, 5'd6, 32'h61, 0, 0, 5'd4, 32'd2,
                      3'b111, 0, 0, 0, 32'h10, 0));
    vecs.push_back(mk(0, 3'b100, 0, 0, 0, 0, 5'd4, 32'd3, 3'b011, 1, 5'd4, 32'd1, 32'h50, 1));
    vecs.push_back(mk(0, 3'b100, 0, 0, 0, 0, 5'd4, 32'd3,
                      3'b111, 1, 5'd6, 32'h61, 32'h50, 1));
    vecs.push_back(mk(0, 3'b101, 5'd6, 32'h62, 0, 0, 5'd4, 32'd4,
                      3'b111, 1, 5'd4, 32'd2, 32'h10, 1));
    vecs.push_back(mk(0, 3'b100, 0, 0, 0, 0, 5'd4, 32'd5, 3'b011, 1, 5'd4, 32'd3, 32'h50, 1));
    vecs.push_back(mk(0, 3'b100, 0, 0, 0, 0, 5'd4, 32'd5,
                      3'b111, 1, 5'd6, 32'h62, 32'h50, 1));
    vecs.push_back(idle(0, 3'b111, 1, 5'd4, 32'd4, 32'h10, 1));
    vecs.push_back(idle(0, 3'b111, 1, 5'd4, 32'd5, 32'h10, 1));
    vecs.push_back(idle(0, 3'b111, 0, 5'd4, 32'd5, 32'h0, 1));

    // Reset state.
    #2;
    chk("reset_rf_we", -1, 32'(rf_we), 32'd0);
    chk("reset_pending", -1, pending, 32'd0);
    chk("reset_waw", -1, 32'(waw_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      chk("ready", i, 32'({div_ready, mul_ready, alu_ready}), 32'(vecs[i].rdy));
      chk("rf_we", i, 32'(rf_we), 32'(vecs[i].we));
      chk("rf_waddr", i, 32'(rf_waddr), 32'(vecs[i].wa));
      chk("rf_wdata", i, rf_wdata, vecs[i].wd);
      chk("pending", i, pending, vecs[i].pend);
      chk("waw_err", i, 32'(waw_err), 32'(vecs[i].waw));
    end

    // Asynchronous reset between edges drops a held result at once.
    @(posedge clk); #1;
    set_idle();
    alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h33;
    @(posedge clk); #1;
    set_idle();
    chk("async_pre_pending", 100, pending, 32'h8);
    rst = 1'b1;
    #1;
    chk("async_pending", 100, pending, 32'h0);
    chk("async_rf_we", 100, 32'(rf_we), 32'd0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("async_no_write", 101 + k, 32'(rf_we), 32'd0);
      chk("async_no_pending", 101 + k, pending, 32'h0);
    end

`ifdef WBARB_STALL_CNT_EN
    do_reset();
    @(negedge clk);
    chk("stall_reset", 200, stall_cnt, 32'd0);
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'h1;
    mul_valid = 1'b1; mul_waddr = 5'd2; mul_wdata = 32'h2;
    div_valid = 1'b1; div_waddr = 5'd3; div_wdata = 32'h3;
    @(posedge clk); #1;
    alu_valid = 1'b0;
    mul_waddr = 5'd5; mul_wdata = 32'h5;
    div_waddr = 5'd6; div_wdata = 32'h6;
    @(negedge clk);
    chk("stall_none_yet", 201, stall_cnt, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_one", 202, stall_cnt, 32'd1);
    @(posedge clk); #1;
    mul_valid = 1'b0;
    @(posedge clk); #1;
    div_valid = 1'b0;
    @(negedge clk);
    chk("stall_two", 203, stall_cnt, 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_hold", 204, stall_cnt, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-side master for the 32x32 register file in the dynamic pipeline.
- Collects results from three independent producers: ALU (src 0), multiplier (src 1) and divider (src 2). Each producer has a valid/ready handshake.
- Buffers one result per producer. Issues at most one registered write per cycle on the register-file write port (we/waddr/wdata).
- Exports a pending-destination vector that the issue stage uses for hazard checks.

Parameters:
- DATA_W, 32, result/write-data width.
- ADDR_W, 5, register address width; register 0 is hardwired zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid / mul_valid / div_valid  in  1 each  producer result valid.
- alu_ready / mul_ready / div_ready  out  1 each  slot can accept a result this cycle.
- alu_waddr / mul_waddr / div_waddr  in  ADDR_W each  destination register.
- alu_wdata / mul_wdata / div_wdata  in  DATA_W each  result data.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  ADDR_W  register-file write address (registered).
- rf_wdata  out  DATA_W  register-file write data (registered).
- pending  out  32  bit r=1 when register r has a write held in a slot or currently on rf_*.
- waw_err  out  1  sticky write-after-write contract-violation flag.

Behaviour:
- Reset: clears all slot valid bits and sets RR pointer=0. Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, waw_err=0.
- Reset mid-operation: held results are discarded; no write issues after reset is released until a new handshake occurs.
- Slot per source i holds h_valid[i], h_addr[i], h_data[i].
- ready[i] = !h_valid[i] || grant[i] (combinational). A slot that drains this cycle can refill in the same cycle.
- Transfer: valid[i] && ready[i] at a rising edge loads the slot.
- Zero-register writes: a transfer with waddr==0 is accepted (ready honoured) but discarded. h_valid stays 0, no rf write is issued, pending is unaffected.
- Arbitration (combinational, one grant per cycle):
  - Round-robin among h_valid slots, searching from pointer p.
  - On a grant to slot k, p <= (k+1) mod 3. With no grant, p holds.
- Output stage: at each edge, rf_we <= |grant, and rf_waddr/rf_wdata <= the granted slot's contents. With no grant, rf_we <= 0 and rf_waddr/rf_wdata hold their previous values.
- Latency:
  - Handshake at edge N; earliest rf_we=1 after edge N+1; register file commits at edge N+2.
  - Worst case with all slots full: 3 cycles to drain.
- Throughput: 1 write per cycle sustained.
- pending:
  - Combinational OR of one-hot(h_addr[i]) over valid slots, plus one-hot(rf_waddr) when rf_we=1.
  - Bit 0 is always 0.
- WAW contract: the issue stage must never have two outstanding writes to the same nonzero register.
  - Violation detection: any accepting transfer whose waddr already has its pending bit set, or two transfers in the same edge with equal nonzero waddr.
  - On violation: waw_err <= 1 and stays set until reset.
  - Data is still accepted; the order of those writes is undefined.
- Simultaneous events:
  - All three valid with empty slots: all three are accepted in one edge.
  - Writes then issue in RR order starting at p.

Optional Feature:
- Macro WBARB_STALL_CNT_EN.
- Defined: adds output stall_cnt (32 bits, reset 0). It increments by 1 on each edge where some valid[i]=1 && ready[i]=0, and wraps at 2^32-1 -> 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then alu_valid=1, waddr=5, wdata=0x1234 for 1 cycle -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 exactly one cycle after the handshake edge. pending[5] is high from the handshake until rf_we drops.
- All three valid in the same cycle (alu r1=0xA, mul r2=0xB, div r3=0xC) after reset -> three consecutive rf writes in order r1, r2, r3. rf_we then returns to 0 and pending=0.
- div_valid held high continuously (r4, values 1,2,3,...) while alu_valid also pulses -> slots alternate by RR, neither source waits more than 2 cycles, and div_ready deasserts only while its slot is full and not granted.
- mul_valid with waddr=0, wdata=0xFFFFFFFF -> mul_ready=1, no rf_we pulse, pending stays 0.
- alu writes r7, then mul writes r7 while the alu entry is still pending -> waw_err=1 and stays 1; assert rst mid-stream -> all outputs return to reset values immediately, with no subsequent rf_we.
- With WBARB_STALL_CNT_EN: hold mul slot full (3 sources contending, mul blocked 2 cycles) -> stall_cnt=2. Without the macro, the design elaborates with no stall_cnt port.
